button_alu: RTL and testbench
=============================

BUTTON_ALU -- requirements
Module: button_alu

Interface
REQ-001 SHALL have parameter BITS, default 16: switch/LED width; only 16 is supported.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 250000: stable-level cycles required before a debounced button changes.
REQ-003 SHALL have port clk, input, 1: sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port SW, input, BITS: operand switches; SW[15:8] is A and SW[7:0] is B for arithmetic.
REQ-006 SHALL have ports BTNU, BTND, BTNL, BTNR, BTNC, input, 1 each: raw asynchronous buttons selecting leading-ones, num-ones, add, sub and mult.
REQ-007 SHALL have port LED, output, BITS: last completed result.
REQ-008 SHALL have port busy, output, 1: high while in COMPUTE.
REQ-009 SHALL have port done, output, 1: one-cycle pulse when LED is updated.

Function
REQ-010 SHALL pass each button through a 2-flop synchronizer, then a debounce counter; the debounced level SHALL change only after DEBOUNCE_CYCLES consecutive cycles at the new synchronized level.
REQ-011 SHALL reset a button's debounce counter whenever its synchronized level equals its debounced level, so shorter glitches are discarded.
REQ-012 SHALL generate a one-cycle press pulse on each debounced 0->1 transition; holding a button SHALL produce only one pulse.
REQ-013 SHALL implement the states IDLE and COMPUTE.
REQ-014 SHALL, on a clock edge in IDLE with any press pulse, capture SW into an operand register, latch the opcode, clear the step counter and enter COMPUTE.
REQ-015 SHALL resolve simultaneous press pulses by priority U > D > L > R > C and drop the lower-priority presses.
REQ-016 SHALL ignore press pulses in COMPUTE; they are not queued.
REQ-017 SHALL make SW changes after capture have no effect on the result.
REQ-018 SHALL perform one step per cycle in COMPUTE with step counts ADD=1, SUB=1, MULT=8 and LO=NO=16.
REQ-019 SHALL, on the final step, write LED, assert done for exactly that one following cycle and return to IDLE, so LED is valid in the same cycle as done.
REQ-020 SHALL compute LO as the index+1 of the highest set bit of SW[15:0] (0 if none), zero-extended to 16 bits, by a sequential 16-step scan.
REQ-021 SHALL compute NO as the popcount of SW[15:0], zero-extended, by a sequential 16-step accumulation.
REQ-022 SHALL compute ADD as signed(A)+signed(B) and SUB as signed(A)-signed(B), sign-extended to 16 bits with no overflow possible.
REQ-023 SHALL compute MULT as the signed 8x8 product of A and B as a 16-bit two's-complement value by 8-step sequential shift-add with sign handling, and SHALL instantiate no DSP or behavioural multiply operator.
REQ-024 SHALL hold LED between completions; busy SHALL equal (state==COMPUTE).
REQ-025 SHALL, when a press pulse occurs on the same edge that COMPUTE completes, ignore that press.

Reset
REQ-026 SHALL, on reset high at a clock edge, set state=IDLE, LED=0, busy=0, done=0, and clear synchronizers, debounced levels, counters and operand registers.
REQ-027 SHALL, on reset during COMPUTE, abort the operation with no done pulse and leave LED=0.
REQ-028 SHALL, while reset is held, treat buttons as unpressed; a button still held after reset release SHALL produce a press only after full debounce.

Verification (DEBOUNCE_CYCLES=4)
REQ-029 SHALL verify: SW=0x0305, BTNL held 10 cycles -> exactly one done, LED=0x0008; SW=0x807F, BTNR -> LED=0xFF01.
REQ-030 SHALL verify: SW=0xFB03, BTNC -> busy for 8 cycles, LED=0xFFF1; SW=0x8080, BTNC -> LED=0x4000.
REQ-031 SHALL verify: SW=0x0000, BTNU -> LED=0x0000; SW=0x8001, BTNU -> 0x0010; SW=0xFFFF, BTND -> 0x0010; SW=0x0001, BTND -> 0x0001.
REQ-032 SHALL verify: a 3-cycle BTNR glitch -> no done and LED unchanged; BTNU+BTNC rising together -> LO result only.
REQ-033 SHALL verify: BTNL pressed and SW changed during a MULT -> only the MULT result from the captured SW, one done.
REQ-034 SHALL verify: reset asserted in cycle 4 of an LO scan -> next cycle LED=0, busy=0, and no done thereafter.

Source files
------------

// File: rtl/button_alu.sv
// button_alu: five debounced push-buttons start a small multi-cycle ALU
// operating on the switch bank; the result is held on the LEDs.
module button_alu #(
  parameter int BITS            = 16,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [BITS-1:0] SW,
  input  logic            BTNU,
  input  logic            BTND,
  input  logic            BTNL,
  input  logic            BTNR,
  input  logic            BTNC,
  output logic [BITS-1:0] LED,
  output logic            busy,
  output logic            done
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_COMPUTE = 1'b1;

  localparam logic [2:0] OP_LO  = 3'd0;
  localparam logic [2:0] OP_NO  = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_MUL = 3'd4;

  // Button vector order: [4]=U [3]=D [2]=L [1]=R [0]=C (priority high to low)
  logic [4:0]    w_btn_raw;
  logic [4:0]    r_sync1;
  logic [4:0]    r_sync2;
  logic [4:0]    r_deb;
  logic [4:0]    r_deb_d;
  logic [CW-1:0] r_cnt [5];
  logic [4:0]    w_press;

  logic [0:0]    r_state;
  logic [2:0]    r_op;
  logic [15:0]   r_op_sw;
  logic [3:0]    r_step;
  logic [3:0]    r_last;
  logic [15:0]   r_acc;
  logic [15:0]   r_mcand;
  logic [15:0]   r_led;
  logic          r_done;

  logic [2:0]    w_op;
  logic [3:0]    w_last;
  logic          w_scan_bit;
  logic          w_mul_bit;
  logic [4:0]    w_idx1;
  logic [15:0]   w_a_ext;
  logic [15:0]   w_b_ext;
  logic [15:0]   w_acc_next;
  logic          w_final;

  assign w_btn_raw = {BTNU, BTND, BTNL, BTNR, BTNC};
  assign w_press   = r_deb & ~r_deb_d;

  // Two-flop synchronizers for the asynchronous buttons
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: level follows the synchronized input only after it has differed for DEBOUNCE_CYCLES cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      r_deb   <= '0;
      r_deb_d <= '0;
      for (int unsigned i = 0; i < 5; i++) r_cnt[i] <= '0;
    end else begin
      r_deb_d <= r_deb;
      for (int unsigned i = 0; i < 5; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          r_deb[i] <= r_sync2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Priority encode simultaneous presses into an opcode and its final step index
  always_comb begin
    w_op   = OP_ADD;
    w_last = 4'd0;
    if (w_press[4]) begin
      w_op   = OP_LO;
      w_last = 4'd15;
    end else if (w_press[3]) begin
      w_op   = OP_NO;
      w_last = 4'd15;
    end else if (w_press[2]) begin
      w_op   = OP_ADD;
      w_last = 4'd0;
    end else if (w_press[1]) begin
      w_op   = OP_SUB;
      w_last = 4'd0;
    end else if (w_press[0]) begin
      w_op   = OP_MUL;
      w_last = 4'd7;
    end
  end

  assign w_scan_bit = r_op_sw[r_step];
  assign w_mul_bit  = r_op_sw[r_step[2:0]];
  assign w_idx1     = {1'b0, r_step} + 5'd1;
  assign w_a_ext    = {{8{r_op_sw[15]}}, r_op_sw[15:8]};
  assign w_b_ext    = {{8{r_op_sw[7]}},  r_op_sw[7:0]};
  assign w_final    = (r_step == r_last);

  // One datapath step; the multiplier's bit 7 has negative weight, so that partial product is subtracted
  always_comb begin
    w_acc_next = r_acc;
    case (r_op)
      OP_LO:   if (w_scan_bit) w_acc_next = {11'b0, w_idx1};
      OP_NO:   w_acc_next = r_acc + {15'b0, w_scan_bit};
      OP_ADD:  w_acc_next = w_a_ext + w_b_ext;
      OP_SUB:  w_acc_next = w_a_ext - w_b_ext;
      OP_MUL: begin
        if (w_mul_bit) begin
          if (r_step == 4'd7) w_acc_next = r_acc - r_mcand;
          else                w_acc_next = r_acc + r_mcand;
        end
      end
      default: w_acc_next = r_acc;
    endcase
  end

  // Control FSM: capture operands on a press in IDLE, step until the final step, then publish the result
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_op    <= OP_LO;
      r_op_sw <= '0;
      r_step  <= '0;
      r_last  <= '0;
      r_acc   <= '0;
      r_mcand <= '0;
      r_led   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (|w_press) begin
            r_op_sw <= SW[15:0];
            r_op    <= w_op;
            r_last  <= w_last;
            r_step  <= '0;
            r_acc   <= '0;
            r_mcand <= {{8{SW[15]}}, SW[15:8]};
            r_state <= S_COMPUTE;
          end
        end
        S_COMPUTE: begin
          r_acc   <= w_acc_next;
          r_mcand <= {r_mcand[14:0], 1'b0};
          r_step  <= r_step + 4'd1;
          if (w_final) begin
            r_led   <= w_acc_next;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign LED  = BITS'(r_led);
  assign busy = (r_state == S_COMPUTE);
  assign done = r_done;

endmodule

// File: tb/tb_button_alu.sv
// Directed self-checking bench for button_alu with a short debounce window.
module tb_button_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] SW;
  logic [4:0]  btn;
  logic [15:0] LED;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int busy_cnt = 0;

  always #5 clk = ~clk;

  button_alu #(.BITS(16), .DEBOUNCE_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .SW    (SW),
    .BTNU  (btn[4]),
    .BTND  (btn[3]),
    .BTNL  (btn[2]),
    .BTNR  (btn[1]),
    .BTNC  (btn[0]),
    .LED   (LED),
    .busy  (busy),
    .done  (done)
  );

  // Count done pulses and busy cycles shortly after each rising edge
  always @(posedge clk) begin
    #2;
    if (done === 1'b1) done_cnt++;
    if (busy === 1'b1) busy_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one operation over a fixed 45-cycle window. Optional second event:
  // BTNL raised at l_at (held to cycle 30) and SW replaced at sw_at (negative = unused).
  task automatic run_op(input string tag, input logic [15:0] sw, input logic [4:0] b,
                        input int hold, input int l_at, input int sw_at,
                        input logic [15:0] sw_new, input logic [15:0] exp_led,
                        input int exp_done, input int exp_busy);
    done_cnt = 0;
    busy_cnt = 0;
    for (int c = 0; c < 45; c++) begin
      if (c == 0)     begin SW = sw; btn = b; end
      if (c == hold)  btn = btn & ~b;
      if (c == l_at)  btn[2] = 1'b1;
      if (c == 30)    btn[2] = 1'b0;
      if (c == sw_at) SW = sw_new;
      @(negedge clk);
    end
    chk({tag, "_led"},  LED, {16'h0, exp_led});
    chk({tag, "_done"}, done_cnt, exp_done);
    chk({tag, "_busy"}, busy_cnt, exp_busy);
  endtask

  initial begin
    bit found;
    reset = 1'b1;
    SW    = 16'h0;
    btn   = 5'b0;
    cyc(3);
    chk("rst_led",  LED,  32'h0);
    chk("rst_busy", busy, 32'h0);
    chk("rst_done", done, 32'h0);
    reset = 1'b0;
    cyc(2);

    //      tag          SW       btn       hold l_at sw_at sw_new    exp_led  done busy
    run_op("add",        16'h0305, 5'b00100, 10,  -1,  -1,  16'h0,    16'h0008, 1,  1);
    run_op("sub",        16'h807F, 5'b00010,  8,  -1,  -1,  16'h0,    16'hFF01, 1,  1);
    run_op("mul_neg",    16'hFB03, 5'b00001,  8,  -1,  -1,  16'h0,    16'hFFF1, 1,  8);
    run_op("mul_min",    16'h8080, 5'b00001,  8,  -1,  -1,  16'h0,    16'h4000, 1,  8);
    run_op("lo_zero",    16'h0000, 5'b10000,  8,  -1,  -1,  16'h0,    16'h0000, 1, 16);
    run_op("lo_top",     16'h8001, 5'b10000,  8,  -1,  -1,  16'h0,    16'h0010, 1, 16);
    run_op("no_all",     16'hFFFF, 5'b01000,  8,  -1,  -1,  16'h0,    16'h0010, 1, 16);
    run_op("glitch",     16'h1234, 5'b00010,  3,  -1,  -1,  16'h0,    16'h0010, 0,  0);
    run_op("prio_uc",    16'h0305, 5'b10001,  8,  -1,  -1,  16'h0,    16'h000A, 1, 16);
    run_op("mul_ignore", 16'h0305, 5'b00001,  8,   3,   8,  16'h7F7F, 16'h000F, 1,  8);

    // Button held through reset: no press until a full debounce after release
    SW    = 16'h0001;
    btn   = 5'b01000;
    reset = 1'b1;
    cyc(3);
    reset    = 1'b0;
    done_cnt = 0;
    cyc(5);
    chk("held_early_done", done_cnt, 32'd0);
    chk("held_early_busy", busy, 32'h0);
    cyc(35);
    chk("held_done", done_cnt, 32'd1);
    chk("held_led",  LED, 32'h0001);
    btn = 5'b0;
    cyc(10);

    // Reset in the fourth cycle of an LO scan aborts with no done and LED cleared
    SW    = 16'h8001;
    btn   = 5'b10000;
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clk);
      if (busy === 1'b1) found = 1'b1;
    end
    chk("abort_busy_seen", {31'h0, found}, 32'h1);
    cyc(3);
    reset = 1'b1;
    btn   = 5'b0;
    cyc(1);
    chk("abort_led",  LED,  32'h0);
    chk("abort_busy", busy, 32'h0);
    cyc(1);
    reset    = 1'b0;
    done_cnt = 0;
    cyc(40);
    chk("abort_no_done", done_cnt, 32'd0);
    chk("abort_led_hold", LED, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
